// File: rtl/cache_nway_pkg.sv
// Shared types and address-field helpers for the N-way set-associative cache.
package cache_nway_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFillReq,
        StFillWait,
        StWrite
    } state_e;

    // Byte offset bits within a line: word select plus the two byte bits.
    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned sets,
                                             input int unsigned line_words);
        return 32 - idx_bits(sets) - off_bits(line_words);
    endfunction

    // A direct-mapped cache still needs a one-bit way index to keep ports legal.
    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Replace the enabled bytes of old_word with wdata.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [3:0]  mask,
                                               input logic [31:0] wdata);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: lowest-index invalid way, otherwise the set's round-robin pointer.
module cache_victim_sel
    import cache_nway_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned WAY_W = way_bits(WAYS)
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [WAY_W-1:0] rr_i,
    output logic [WAY_W-1:0] victim_o
);

    // Scan downwards so the lowest invalid way wins.
    always_comb begin
        victim_o = rr_i;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WAY_W'(w);
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative, write-through, write-allocate cache with line refill FSM.
// Optional hit/miss counters are built when CACHE_NWAY_STATS_EN is defined.
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int unsigned SETS       = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
`ifdef CACHE_NWAY_STATS_EN
    output logic [31:0] o_stat_hits,
    output logic [31:0] o_stat_misses,
`endif
    output logic [31:0] o_res_rdata
);

    localparam int unsigned OFF_W  = off_bits(LINE_WORDS);
    localparam int unsigned WORD_W = OFF_W - 2;
    localparam int unsigned IDX_W  = idx_bits(SETS);
    localparam int unsigned TAG_W  = tag_bits(SETS, LINE_WORDS);
    localparam int unsigned WAY_W  = way_bits(WAYS);

    localparam logic [WORD_W-1:0] LastBeat = WORD_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0]  LastWay  = WAY_W'(WAYS - 1);

    // Storage arrays
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];

    // FSM and latched request
    state_e           state_q;
    logic [31:2]      addr_q;
    logic [3:0]       mask_q;
    logic [31:0]      wdata_q;
    logic             wr_q;
    logic [WAY_W-1:0] way_q;
    logic [WORD_W-1:0] beat_q;
    logic             mem_ren_q;
    logic             mem_wen_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;

    // Live request fields
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic              req_any;

    assign req_idx  = i_req_addr[OFF_W +: IDX_W];
    assign req_tag  = i_req_addr[31 -: TAG_W];
    assign req_word = i_req_addr[2 +: WORD_W];
    assign req_any  = i_req_ren | i_req_wen;

    // Byte lane bits are ignored; the cache is word-granular.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_req_addr[1:0];

    // Latched request fields
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic [WORD_W-1:0] lat_word;

    assign lat_idx  = addr_q[OFF_W +: IDX_W];
    assign lat_tag  = addr_q[31 -: TAG_W];
    assign lat_word = addr_q[2 +: WORD_W];

    // Tag compare across all ways of the indexed set
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [31:0]       hit_word;

    // Hit detection and read-data mux; at most one way can match.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_word = data_q[w][req_idx][req_word];
            end
        end
    end

    logic [WAY_W-1:0] victim_way;

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_i  (valid_q[req_idx]),
        .rr_i     (rr_q[req_idx]),
        .victim_o (victim_way)
    );

    // On the last beat the requested word may be arriving right now rather than stored.
    logic [31:0] fill_old;
    assign fill_old = (beat_q == lat_word) ? i_mem_rdata : data_q[way_q][lat_idx][lat_word];

    // FSM, latched request, registered memory-side outputs, valid bits and RR pointers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            way_q       <= '0;
            beat_q      <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_any && (!hit || i_req_wen)) begin
                        addr_q  <= i_req_addr[31:2];
                        mask_q  <= i_req_mask;
                        wdata_q <= i_req_wdata;
                        wr_q    <= i_req_wen;
                        if (!hit) begin
                            way_q      <= victim_way;
                            beat_q     <= '0;
                            mem_ren_q  <= 1'b1;
                            mem_addr_q <= {i_req_addr[31:OFF_W], {OFF_W{1'b0}}};
                            state_q    <= StFillReq;
                        end else begin
                            way_q       <= hit_way;
                            mem_wen_q   <= 1'b1;
                            mem_addr_q  <= {i_req_addr[31:2], 2'b00};
                            mem_wdata_q <= merge_word(hit_word, i_req_mask, i_req_wdata);
                            state_q     <= StWrite;
                        end
                    end
                end
                StFillReq: begin
                    if (i_mem_ready) begin
                        mem_ren_q <= 1'b0;
                        state_q   <= StFillWait;
                    end
                end
                StFillWait: begin
                    if (i_mem_valid) begin
                        if (beat_q == LastBeat) begin
                            // Line only becomes visible once every beat has landed.
                            valid_q[lat_idx][way_q] <= 1'b1;
                            rr_q[lat_idx] <= (rr_q[lat_idx] == LastWay) ? '0
                                           : rr_q[lat_idx] + WAY_W'(1);
                            if (wr_q) begin
                                mem_wen_q   <= 1'b1;
                                mem_addr_q  <= {addr_q, 2'b00};
                                mem_wdata_q <= merge_word(fill_old, mask_q, wdata_q);
                                state_q     <= StWrite;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            beat_q     <= beat_q + WORD_W'(1);
                            mem_ren_q  <= 1'b1;
                            mem_addr_q <= {addr_q[31:OFF_W], beat_q + WORD_W'(1), 2'b00};
                            state_q    <= StFillReq;
                        end
                    end
                end
                StWrite: begin
                    if (i_mem_ready) begin
                        mem_wen_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Data and tag storage; no reset needed since valid bits gate every use.
    always_ff @(posedge i_clk) begin
        if (state_q == StFillWait && i_mem_valid) begin
            data_q[way_q][lat_idx][beat_q] <= i_mem_rdata;
            if (beat_q == LastBeat) tag_q[way_q][lat_idx] <= lat_tag;
        end
        if (state_q == StWrite && i_mem_ready) begin
            data_q[way_q][lat_idx][lat_word] <= mem_wdata_q;
        end
    end

    assign o_busy      = (state_q != StIdle) | (req_any & (~hit | i_req_wen));
    assign o_res_rdata = hit_word;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_ren   = mem_ren_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_wdata = mem_wdata_q;

`ifdef CACHE_NWAY_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    // Saturating hit/miss counters, one event per request seen in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == StIdle && req_any) begin
            if (hit) begin
                if (hits_q != '1) hits_q <= hits_q + 32'd1;
            end else begin
                if (misses_q != '1) misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign o_stat_hits   = hits_q;
    assign o_stat_misses = misses_q;
`endif

endmodule
